// File: rtl/death_transition_pkg.sv
// Shared types and constants for the death-screen transition: state encoding, RGB565 layout, fade level.
// Pure declarations with no logic, so it has no latency and no flow control.
package death_transition_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    FADE  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  localparam int              LVL_W   = 4;
  localparam logic [LVL_W-1:0] LVL_MAX = 4'd8;

  function automatic logic [15:0] invert565(input logic [15:0] p);
    return p ^ WHITE;
  endfunction

endpackage

// File: rtl/death_transition_rgb565_scale.sv
// Combinational RGB565 dimmer: each channel becomes (channel * level) >> 3 for level 0..8.
// Zero latency; no flow control.
module rgb565_scale
  import death_transition_pkg::*;
(
  input  logic [15:0]      pixel,
  input  logic [LVL_W-1:0] level,
  output logic [15:0]      scaled
);

  // Products are one level-width wider than the channel, so level 8 cannot overflow.
  logic [R_W+LVL_W-1:0] r_p;
  logic [G_W+LVL_W-1:0] g_p;
  logic [B_W+LVL_W-1:0] b_p;

  always_comb begin
    r_p = pixel[R_LSB +: R_W] * level;
    g_p = pixel[G_LSB +: G_W] * level;
    b_p = pixel[B_LSB +: B_W] * level;
    scaled = {R_W'(r_p >> 3), G_W'(g_p >> 3), B_W'(b_p >> 3)};
  end

endmodule

// File: rtl/death_transition.sv
// Death-screen sequencer PLAY -> [FLASH] -> FADE -> DEAD -> PLAY; FLASH exists only with DEATH_TRANSITION_FLASH_EN.
// oled_data is 1 clk behind the pixel inputs in every state; no backpressure, state moves only on frame_begin.
module death_transition
  import death_transition_pkg::*;
#(
  parameter int FLASH_FRAMES    = 6,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic        death_trig,
  input  logic        restart_btn,
  input  logic [15:0] game_pixel,
  input  logic [15:0] death_pixel,
  output logic [15:0] oled_data,
  output logic        busy,
  output logic        dead
);

  localparam int CNT_MAX = (FLASH_FRAMES > FRAMES_PER_STEP) ? FLASH_FRAMES : FRAMES_PER_STEP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [LVL_W-1:0] lvl, lvl_nx;
  logic             death_pend, restart_pend, restart_q, restart_rise;
  logic [15:0]      faded, pix_d;

  assign restart_rise = restart_btn & ~restart_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLAY;
      cnt          <= '0;
      lvl          <= '0;
      death_pend   <= 1'b0;
      restart_pend <= 1'b0;
      restart_q    <= 1'b0;
      oled_data    <= BLACK;
      busy         <= 1'b0;
      dead         <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lvl       <= lvl_nx;
      restart_q <= restart_btn;
      // Requests wait for the next frame boundary and are dropped once it is taken.
      if (state_nx != state) begin
        death_pend   <= 1'b0;
        restart_pend <= 1'b0;
      end else begin
        death_pend   <= death_pend   | ((state == PLAY) & death_trig);
        restart_pend <= restart_pend | ((state == DEAD) & restart_rise);
      end
      oled_data <= pix_d;
      busy      <= (state_nx == FLASH) || (state_nx == FADE);
      dead      <= (state_nx == DEAD);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lvl_nx   = lvl;
    if (frame_begin) begin
      cnt_nx = cnt + 1'b1;
      case (state)
        PLAY: if (death_trig || death_pend) begin
`ifdef DEATH_TRANSITION_FLASH_EN
          state_nx = FLASH;
`else
          state_nx = FADE;
`endif
        end
`ifdef DEATH_TRANSITION_FLASH_EN
        FLASH: if (cnt == CNT_W'(FLASH_FRAMES - 1)) state_nx = FADE;
`endif
        FADE: if (cnt == CNT_W'(FRAMES_PER_STEP - 1)) begin
          cnt_nx = '0;
          if (lvl == LVL_MAX) state_nx = DEAD;
          else                lvl_nx   = lvl + 1'b1;
        end
        DEAD: if (restart_rise || restart_pend) state_nx = PLAY;
        default: state_nx = PLAY;
      endcase
      // The boundary pulse that changes state is frame 0 of the new state.
      if (state_nx != state) begin
        cnt_nx = '0;
        lvl_nx = '0;
      end
    end
  end

  rgb565_scale u_scale (
    .pixel  (death_pixel),
    .level  (lvl_nx),
    .scaled (faded)
  );

  // Driven from the next-state view so the pixel sharing a cycle with frame_begin already belongs to the new frame.
  always_comb begin
    pix_d = BLACK;
    case (state_nx)
      PLAY:  pix_d = game_pixel;
`ifdef DEATH_TRANSITION_FLASH_EN
      FLASH: pix_d = cnt_nx[0] ? invert565(game_pixel) : game_pixel;
`endif
      FADE:  pix_d = faded;
      DEAD:  pix_d = death_pixel;
      default: pix_d = BLACK;
    endcase
  end

endmodule

// File: tb/tb_death_transition.sv
// Directed bench for death_transition: vector table for PLAY/entry, hand sequences for flash, fade, dead, restart, reset.
// Follows DEATH_TRANSITION_FLASH_EN like the design.
module tb_death_transition;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic        death_trig = 1'b0;
  logic        restart_btn = 1'b0;
  logic [15:0] game_pixel = 16'h0000;
  logic [15:0] death_pixel = 16'h0000;
  logic [15:0] oled_data;
  logic        busy, dead;

  int n_vec  = 0;
  int n_miss = 0;

  death_transition dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_begin (frame_begin),
    .death_trig  (death_trig),
    .restart_btn (restart_btn),
    .game_pixel  (game_pixel),
    .death_pixel (death_pixel),
    .oled_data   (oled_data),
    .busy        (busy),
    .dead        (dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fb, dt, rb;
    logic [15:0] gp, dp, exp_pix;
    logic        exp_busy, exp_dead;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] pix, input logic b, input logic d);
    chk({name, ".oled"}, oled_data, pix);
    chk({name, ".busy"}, {15'd0, busy}, {15'd0, b});
    chk({name, ".dead"}, {15'd0, dead}, {15'd0, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame_begin cycle; outputs afterwards reflect the first pixel of the frame.
  task automatic start_frame(input logic [15:0] gp, input logic [15:0] dp);
    game_pixel  = gp;
    death_pixel = dp;
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
  endtask

  function automatic logic [15:0] exp_fade(input logic [15:0] p, input int l);
    int r, g, b;
    r = (int'(p[15:11]) * l) / 8;
    g = (int'(p[10:5])  * l) / 8;
    b = (int'(p[4:0])   * l) / 8;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  initial begin
    int flash_frames;
`ifdef DEATH_TRANSITION_FLASH_EN
    flash_frames = 6;
`else
    flash_frames = 0;
`endif

    //            fb    dt    rb    gp        dp        exp       busy  dead
    vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h1234, 16'h0F0F, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'hABCD, 16'h0F0F, 16'hABCD, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h5555, 16'hFFFF, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'hAAAA, 16'hFFFF, 16'hAAAA, 1'b0, 1'b0};
`ifdef DEATH_TRANSITION_FLASH_EN
    vecs[6] = '{1'b1, 1'b0, 1'b1, 16'hF800, 16'hFFFF, 16'hF800, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 16'hF800, 16'hFFFF, 16'hF800, 1'b1, 1'b0};
`else
    vecs[6] = '{1'b1, 1'b0, 1'b1, 16'hF800, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 16'hF800, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
`endif

    // Reset state
    game_pixel = 16'hBEEF;
    tick();
    tick();
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // PLAY pass-through and pending death entry
    for (int i = 0; i < 8; i++) begin
      frame_begin = vecs[i].fb;
      death_trig  = vecs[i].dt;
      restart_btn = vecs[i].rb;
      game_pixel  = vecs[i].gp;
      death_pixel = vecs[i].dp;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pix, vecs[i].exp_busy, vecs[i].exp_dead);
    end
    frame_begin = 1'b0;

`ifdef DEATH_TRANSITION_FLASH_EN
    for (int f = 1; f < 6; f++) begin
      start_frame(16'hF800, 16'hFFFF);
      chk_all($sformatf("flash%0d", f), (f % 2 == 1) ? 16'h07FF : 16'hF800, 1'b1, 1'b0);
      tick();
    end
    start_frame(16'hF800, 16'hFFFF);
    chk_all("flash_to_fade", 16'h0000, 1'b1, 1'b0);
`endif

    // Fade from L=0 (already in frame k=0) through L=8
    for (int k = 1; k < 36; k++) begin
      start_frame(16'h1111, 16'hFFFF);
      chk($sformatf("fade_k%0d", k), oled_data, exp_fade(16'hFFFF, k / 4));
      if (k == 16) chk("fade_L4_white", oled_data, 16'h7BEF);
      if (k == 32) chk("fade_L8_white", oled_data, 16'hFFFF);
      if (k == 8) begin
        death_pixel = 16'hF800;
        tick();
        chk("fade_L2_red", oled_data, 16'h3800);
      end
      if (k == 35) chk_all("fade_last", 16'hFFFF, 1'b1, 1'b0);
    end

    // DEAD entry after 36 fade frames; restart held since before death must not count
    start_frame(16'h0000, 16'h1357);
    chk_all("dead_entry", 16'h1357, 1'b0, 1'b1);
    start_frame(16'h0000, 16'h1357);
    chk_all("dead_held_btn", 16'h1357, 1'b0, 1'b1);
    death_trig = 1'b1;
    start_frame(16'h0000, 16'h2468);
    chk_all("dead_ignore_trig", 16'h2468, 1'b0, 1'b1);
    death_trig = 1'b0;
    restart_btn = 1'b0;
    tick();
    restart_btn = 1'b1;
    tick();
    chk_all("dead_press_midframe", 16'h2468, 1'b0, 1'b1);
    restart_btn = 1'b0;
    tick();
    start_frame(16'h2468, 16'h1357);
    chk_all("restart_play", 16'h2468, 1'b0, 1'b0);

    // Reset mid-fade at L=5
    death_trig = 1'b1;
    start_frame(16'h4321, 16'hFFFF);
    death_trig = 1'b0;
    for (int f = 0; f < flash_frames + 20; f++) start_frame(16'h4321, 16'hFFFF);
    chk_all("fade_L5", 16'h9CF3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 16'h0000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    start_frame(16'h1234, 16'hFFFF);
    chk_all("post_reset_play", 16'h1234, 1'b0, 1'b0);
    tick();
    chk_all("post_reset_mid", 16'h1234, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
